// File: rtl/four_bit_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package four_bit_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the only arithmetic element in the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/four_bit_serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a + ~b + 1, one bit per cycle, LSB first.
// state | meaning
// IDLE  | in_ready=1, waiting for operands
// SHIFT | one bit per cycle through the full adder
// DONE  | result presented, held until out_ready
module four_bit_serial_subtractor
  import four_bit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] nb_sh_q, nb_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_msb_q, c_msb_d;
  logic             out_valid_q, out_valid_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] res_next;

  full_adder u_fa (
    .a   (a_sh_q[0]),
    .b   (nb_sh_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .cout(fa_c)
  );

  // Sum bits enter at the MSB so the last bit lands the whole word in place.
  assign res_next = {fa_s, res_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    nb_sh_d     = nb_sh_q;
    res_d       = res_q;
    diff_d      = diff_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    c_msb_d     = c_msb_q;
    out_valid_d = out_valid_q;
    borrow_d    = borrow_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d   = a;
          nb_sh_d  = ~b;
          carry_d  = 1'b1;
          cnt_d    = '0;
          res_d    = '0;
          diff_d   = '0;
          borrow_d = 1'b0;
          ovf_d    = 1'b0;
          zero_d   = 1'b0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        res_d   = res_next;
        a_sh_d  = a_sh_q >> 1;
        nb_sh_d = nb_sh_q >> 1;
        carry_d = fa_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 2)) c_msb_d = fa_c;
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d      = res_next;
          borrow_d    = ~fa_c;
          ovf_d       = c_msb_q ^ fa_c;
          zero_d      = (res_next == '0);
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      nb_sh_q     <= '0;
      res_q       <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b1;
      c_msb_q     <= 1'b0;
      out_valid_q <= 1'b0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      nb_sh_q     <= nb_sh_d;
      res_q       <= res_d;
      diff_q      <= diff_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      c_msb_q     <= c_msb_d;
      out_valid_q <= out_valid_d;
      borrow_q    <= borrow_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_four_bit_serial_subtractor.sv
// Scoreboard bench for the serial subtractor: directed corner cases, backpressure, reset abort, exhaustive pairs.
module tb_four_bit_serial_subtractor;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic         br;
    logic         ov;
    logic         z;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;
  logic         zero;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  four_bit_serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .borrow   (borrow),
    .ovf      (ovf),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    e.d  = av - bv;
    e.br = (av < bv);
    e.ov = (av[W-1] != bv[W-1]) && (e.d[W-1] != av[W-1]);
    e.z  = (e.d == '0);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; poke drives a stray operand during the DONE stall and release cycle.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int stall, input logic poke);
    int   n;
    exp_t e;
    logic [W+2:0] hold;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (n >= 50) check("wait_in_ready", 0, 1);
    a = av; b = bv; in_valid = 1'b1;
    sb.push_back(model(av, bv));
    tick();
    in_valid = 1'b0;
    check("busy_in_ready", in_ready, 0);
    n = 0;
    while (!out_valid && n < 50) begin
      check("diff_cleared", {diff, borrow, ovf, zero}, 0);
      tick();
      n++;
    end
    check("latency", n, W);
    hold = {diff, borrow, ovf, zero};
    for (int i = 0; i < stall; i++) begin
      if (poke) begin a = 4'd1; b = 4'd1; in_valid = 1'b1; end
      tick();
      check("stall_valid", out_valid, 1);
      check("stall_data", {diff, borrow, ovf, zero}, hold);
      check("stall_in_ready", in_ready, 0);
    end
    if (sb.size() == 0) begin
      check("sb_underflow", 0, 1);
    end else begin
      e = sb.pop_front();
      check("diff", diff, e.d);
      check("borrow", borrow, e.br);
      check("ovf", ovf, e.ov);
      check("zero", zero, e.z);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("released_valid", out_valid, 0);
    check("released_idle", in_ready, 1);
    in_valid = 1'b0;
    tick();
    check("no_stray_accept", in_ready, 1);
  endtask

  initial begin
    int n;
    repeat (3) tick();
    check("rst_valid", out_valid, 0);
    check("rst_data", {diff, borrow, ovf, zero}, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    run_op(4'd5, 4'd3, 0, 1'b0);
    run_op(4'd3, 4'd5, 1, 1'b0);
    run_op(4'd8, 4'd1, 0, 1'b0);
    run_op(4'd7, 4'hF, 2, 1'b0);
    run_op(4'd7, 4'd7, 0, 1'b0);
    run_op(4'd0, 4'd0, 0, 1'b0);

    run_op(4'd12, 4'd5, 6, 1'b1);
    run_op(4'd4, 4'd6, 0, 1'b0);

    // Abort mid-operation: no partial result may escape.
    a = 4'd6; b = 4'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("abort_valid", out_valid, 0);
    check("abort_data", {diff, borrow, ovf, zero}, 0);
    check("abort_in_ready", in_ready, 1);
    rst_n = 1'b1;
    n = 0;
    repeat (6) begin tick(); if (out_valid) n++; end
    check("abort_no_result", n, 0);
    run_op(4'd9, 4'd2, 0, 1'b0);

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        run_op(W'(i), W'(j), int'($urandom_range(0, 3)), 1'b0);

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
